// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - PC register, req/ack instruction fetch, next-PC selection
// Optional misaligned-target trap enabled by defining PC_MISALIGN_TRAP_EN.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        branch,
  input  logic        jal,
  input  logic        jalr,
  input  logic [31:0] imm,
  input  logic        C,
  input  logic [31:0] Out_ALU,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        trap
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
`ifdef PC_MISALIGN_TRAP_EN
  localparam logic [1:0] ST_TRAP  = 2'd3;
`endif

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        instr_valid_q, instr_valid_d;
  logic [31:0] next_pc_raw;
  logic [31:0] next_pc;
  logic        misaligned;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    if (jalr) begin
      next_pc_raw = Out_ALU & ~32'h1;
    end else if (jal || (branch && C)) begin
      next_pc_raw = pc_q + imm;
    end else begin
      next_pc_raw = pc_plus4;
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  assign next_pc    = next_pc_raw;
  assign misaligned = (next_pc_raw[1:0] != 2'b00);
`else
  // Without the trap, misaligned targets are silently word-aligned.
  assign next_pc    = next_pc_raw & ~32'h3;
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem_ack) begin
          instr_d       = imem_rdata;
          instr_valid_d = 1'b1;
          state_d       = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (instr_ready) begin
          pc_d          = next_pc;
          instr_valid_d = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
          state_d       = misaligned ? ST_TRAP : ST_FETCH;
`else
          state_d       = misaligned ? ST_IDLE : ST_FETCH;
`endif
        end
      end
`ifdef PC_MISALIGN_TRAP_EN
      ST_TRAP: state_d = ST_TRAP;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= 32'h0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign imem_req    = (state_q == ST_FETCH);
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign pc          = pc_q;
`ifdef PC_MISALIGN_TRAP_EN
  assign trap        = (state_q == ST_TRAP);
`else
  assign trap        = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// tb/tb_pc_fetch.sv - directed self-checking bench for pc_fetch (RESET_PC=0x100)
module tb_pc_fetch;
  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch, jal, jalr, C;
  logic [31:0] imm, Out_ALU;
  logic [31:0] pc, pc_plus4;
  logic        trap;

  int checks = 0;
  int failures = 0;

  pc_fetch #(.RESET_PC(32'h100)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .branch(branch), .jal(jal), .jalr(jalr), .imm(imm), .C(C), .Out_ALU(Out_ALU),
    .pc(pc), .pc_plus4(pc_plus4), .trap(trap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Complete a fetch that is already in FETCH with an immediate ack.
  task automatic do_fetch(input logic [31:0] word);
    imem_ack = 1'b1; imem_rdata = word;
    tick();
    imem_ack = 1'b0;
  endtask

  task automatic resolve(input logic b, input logic j, input logic jr, input logic c,
                         input logic [31:0] im, input logic [31:0] alu);
    instr_ready = 1'b1; branch = b; jal = j; jalr = jr; C = c; imm = im; Out_ALU = alu;
    tick();
    instr_ready = 1'b0; branch = 1'b0; jal = 1'b0; jalr = 1'b0; C = 1'b0;
    imm = 32'h0; Out_ALU = 32'h0;
  endtask

  task automatic jump_to(input logic [31:0] target);
    do_fetch(32'h0000_0067);
    resolve(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, target);
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0;
    branch = 1'b0; jal = 1'b0; jalr = 1'b0; C = 1'b0; imm = 32'h0; Out_ALU = 32'h0;
    tick(); tick();
    check("rst_pc", pc, 32'h100);
    check("rst_req", {31'h0, imem_req}, 32'h0);
    check("rst_addr", imem_addr, 32'h100);
    check("rst_instr", instr, 32'h0);
    check("rst_valid", {31'h0, instr_valid}, 32'h0);
    check("rst_trap", {31'h0, trap}, 32'h0);
    check("rst_plus4", pc_plus4, 32'h104);

    rst = 1'b0;
    check("idle_req", {31'h0, imem_req}, 32'h0);
    tick();
    check("fetch_req", {31'h0, imem_req}, 32'h1);
    check("fetch_addr", imem_addr, 32'h100);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check("ready_in_fetch_pc", pc, 32'h100);
    check("wait_req", {31'h0, imem_req}, 32'h1);
    do_fetch(32'h0000_0013);
    check("hold_valid", {31'h0, instr_valid}, 32'h1);
    check("hold_instr", instr, 32'h13);
    check("hold_req", {31'h0, imem_req}, 32'h0);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    check("ack_in_hold_instr", instr, 32'h13);
    resolve(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("seq_addr", imem_addr, 32'h104);
    check("seq_valid", {31'h0, instr_valid}, 32'h0);
    check("seq_req", {31'h0, imem_req}, 32'h1);

    jump_to(32'h200);
    check("jalr_200", imem_addr, 32'h200);
    do_fetch(32'h1);
    resolve(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF0, 32'h0);
    check("br_taken", imem_addr, 32'h1F0);
    jump_to(32'h200);
    do_fetch(32'h2);
    resolve(1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'h0);
    check("br_not_taken", imem_addr, 32'h204);

    jump_to(32'h300);
    do_fetch(32'h3);
    check("hold_plus4", pc_plus4, 32'h304);
    resolve(1'b0, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0000_0451);
    check("jalr_prio", pc, 32'h450);

    jump_to(32'hFFFF_FFFC);
    do_fetch(32'h4);
    resolve(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("wrap_addr", imem_addr, 32'h0);

    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h5;
    tick();
    rst = 1'b0;
    check("rst_mid_valid", {31'h0, instr_valid}, 32'h0);
    check("rst_mid_addr", imem_addr, 32'h100);
    check("rst_mid_req", {31'h0, imem_req}, 32'h0);
    tick();
    imem_ack = 1'b0;
    check("restart_valid", {31'h0, instr_valid}, 32'h0);
    check("restart_req", {31'h0, imem_req}, 32'h1);

    jump_to(32'h10);
    do_fetch(32'h6);
    resolve(1'b0, 1'b1, 1'b0, 1'b0, 32'h6, 32'h0);
`ifdef PC_MISALIGN_TRAP_EN
    check("trap_on", {31'h0, trap}, 32'h1);
    check("trap_pc", pc, 32'h16);
    tick(); tick();
    check("trap_req", {31'h0, imem_req}, 32'h0);
    check("trap_valid", {31'h0, instr_valid}, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("trap_cleared", {31'h0, trap}, 32'h0);
`else
    check("align_addr", imem_addr, 32'h14);
    check("no_trap", {31'h0, trap}, 32'h0);
    check("align_req", {31'h0, imem_req}, 32'h1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pc_fetch.md
# pc_fetch

Program-counter and instruction-fetch stage of the core. Holds the PC, fetches instructions from instruction memory over a req/ack handshake, presents each instruction to decode, and computes the next PC. Next-PC selection uses the branch condition flag C and the jump target Out_ALU produced by the ALU for the instruction currently held.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address; equals pc while imem_req=1.
- imem_ack  in  1  memory response strobe; imem_rdata valid in that cycle.
- imem_rdata  in  32  fetched instruction word.
- instr  out  32  held instruction to decode.
- instr_valid  out  1  instr is valid.
- instr_ready  in  1  decode/execute has resolved the held instruction; control inputs below are valid this cycle.
- branch  in  1  held instruction is a conditional branch.
- jal  in  1  held instruction is JAL.
- jalr  in  1  held instruction is JALR.
- imm  in  32  sign-extended branch/JAL offset.
- C  in  1  ALU branch-condition flag.
- Out_ALU  in  32  ALU result; JALR target (rs1+imm).
- pc  out  32  PC of held instruction.
- pc_plus4  out  32  pc+4, link value for JAL/JALR.
- trap  out  1  misaligned-target trap active (only with PC_MISALIGN_TRAP_EN).

## Operation
- States: IDLE, FETCH, HOLD, TRAP.
- IDLE: imem_req=0. Always moves to FETCH next cycle.
- FETCH: imem_req=1, imem_addr=pc; both held stable until imem_ack. On imem_ack: instr<=imem_rdata, instr_valid<=1, state -> HOLD.
- HOLD: imem_req=0, instr and instr_valid stable. On instr_ready: pc<=next_pc, instr_valid<=0, state -> FETCH (or TRAP, see Configuration).
- next_pc priority: jalr -> {Out_ALU[31:1],1'b0}; else jal -> pc+imm; else branch&&C -> pc+imm; else pc+4.
- More than one of jalr/jal/branch high: priority above is applied, no error.
- All additions mod 2^32; pc=32'hFFFF_FFFC with sequential flow wraps to 0.
- imem_ack outside FETCH is ignored. instr_ready outside HOLD is ignored.
- pc_plus4 = pc+4 combinationally, always.

## Timing
- Reset values: pc=RESET_PC, state=IDLE, imem_req=0, imem_addr=RESET_PC, instr=0, instr_valid=0, trap=0, pc_plus4=RESET_PC+4.
- First cycle after rst deasserts: IDLE; next cycle imem_req=1.
- Ack in the first FETCH cycle: instr_valid=1 next cycle. Minimum throughput: one instruction per 2 cycles (1 FETCH + 1 HOLD).
- New pc visible the cycle after instr_ready; imem_addr shows it in that same cycle (FETCH).
- rst asserted in any state overrides all else; an imem_ack arriving in the cycle rst is high or during the following IDLE is discarded.
- Control inputs (branch, jal, jalr, imm, C, Out_ALU) sampled only in the HOLD cycle with instr_ready=1.

## Configuration
- PC_MISALIGN_TRAP_EN defined: if selected next_pc[1:0]!=2'b00, pc still loads next_pc, state -> TRAP, trap=1, imem_req=0, instr_valid=0; TRAP left only by rst.
- Not defined: next_pc[1:0] forced to 2'b00; TRAP state absent; trap tied 0.

## Test plan
- Reset with RESET_PC=32'h100, ack after 2 cycles with rdata=32'h00000013, ready high -> imem_addr=32'h100, then 32'h104; instr_valid pulses with instr=32'h13.
- HOLD at pc=32'h200, branch=1, C=1, imm=32'hFFFF_FFF0 -> next imem_addr=32'h1F0; repeat with C=0 -> 32'h204.
- HOLD at pc=32'h300, jalr=1, jal=1, Out_ALU=32'h0000_0451 -> next pc=32'h450 (jalr wins), pc_plus4=32'h304 during HOLD.
- pc=32'hFFFF_FFFC sequential -> next imem_addr=32'h0.
- rst asserted mid-FETCH with imem_ack same cycle -> instr_valid stays 0, imem_addr=RESET_PC, fetch restarts two cycles later.
- With PC_MISALIGN_TRAP_EN: jal, pc=32'h10, imm=32'h6 -> trap=1, imem_req stays 0 until rst; without macro -> next pc=32'h14.
